// File: rtl/sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_drive_ctrl
// Purpose  : Front-end for an SR latch. Two raw asynchronous pushbuttons are
//            synchronised, debounced and rising-edge detected into one-deep
//            pending requests. A small FSM turns those requests into timed,
//            mutually exclusive s/r pulses with a forced idle gap afterwards.
//            Simultaneous set+reset requests are dropped and flagged.
// Ports    : clk      in  system clock, rising edge
//            rst      in  synchronous active-high reset
//            btn_set  in  raw set button (asynchronous, may bounce)
//            btn_rst  in  raw reset button (asynchronous, may bounce)
//            s        out registered set pulse to the latch
//            r        out registered reset pulse to the latch
//            busy     out high while a pulse or gap is in progress
//            conflict out one-cycle flag when set and reset requests collide
// Revision : 1.0 - initial release
// ============================================================================
module sr_drive_ctrl #(
   parameter int DEB_CYCLES   = 4,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_set,
   input  logic btn_rst,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam int MAX_TIM = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int TIM_W   = (MAX_TIM > 1) ? $clog2(MAX_TIM + 1) : 1;

   // Debounce count value at which the next mismatching edge flips the level.
   localparam logic [DEB_W-1:0] C_DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   // Down-counter load values: a phase of N cycles counts N-1 .. 0.
   localparam logic [TIM_W-1:0] C_PULSE_LOAD = TIM_W'(PULSE_CYCLES - 1);
   localparam logic [TIM_W-1:0] C_GAP_LOAD   = (GAP_CYCLES > 0) ? TIM_W'(GAP_CYCLES - 1) : '0;

   // ------------------------------------------------------------------------
   // Per-channel input path: channel 0 = set button, channel 1 = reset button
   // ------------------------------------------------------------------------
   logic [1:0] btn_raw;
   logic [1:0] btn_rise;

   assign btn_raw = {btn_rst, btn_set};

   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic             sync1_q,    sync1_d;
      logic             sync2_q,    sync2_d;
      logic             deb_q,      deb_d;
      logic             deb_prev_q, deb_prev_d;
      logic [DEB_W-1:0] cnt_q,      cnt_d;

      always_comb begin
         sync1_d    = btn_raw[gi];
         sync2_d    = sync1_q;
         deb_d      = deb_q;
         cnt_d      = '0;
         deb_prev_d = deb_q;

         // Count consecutive cycles where the synchronised input disagrees
         // with the debounced level; any agreement restarts the count.
         if (sync2_q != deb_q) begin
            if (cnt_q == C_DEB_LAST) begin
               deb_d = ~deb_q;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
         end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
         end
      end

      // Only a rising debounced level produces a request.
      assign btn_rise[gi] = deb_q & ~deb_prev_q;
   end

   // ------------------------------------------------------------------------
   // Pulse sequencer
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE_S = 2'd1,
      ST_PULSE_R = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   state_t           state_q,    state_d;
   logic [TIM_W-1:0] tim_q,      tim_d;
   logic             set_req_q,  set_req_d;
   logic             rst_req_q,  rst_req_d;
   logic             s_q,        s_d;
   logic             r_q,        r_d;
   logic             busy_q,     busy_d;
   logic             conflict_q, conflict_d;

   always_comb begin
      state_d    = state_q;
      tim_d      = tim_q;
      // One-deep requests: a rise while already pending is simply absorbed.
      set_req_d  = set_req_q | btn_rise[0];
      rst_req_d  = rst_req_q | btn_rise[1];
      conflict_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (set_req_q && rst_req_q) begin
               // Ambiguous intent: drop both and flag it, never drive the latch.
               set_req_d  = 1'b0;
               rst_req_d  = 1'b0;
               conflict_d = 1'b1;
            end else if (set_req_q) begin
               set_req_d = 1'b0;
               state_d   = ST_PULSE_S;
               tim_d     = C_PULSE_LOAD;
            end else if (rst_req_q) begin
               rst_req_d = 1'b0;
               state_d   = ST_PULSE_R;
               tim_d     = C_PULSE_LOAD;
            end
         end

         ST_PULSE_S, ST_PULSE_R: begin
            if (tim_q == '0) begin
               if (GAP_CYCLES > 0) begin
                  state_d = ST_GAP;
                  tim_d   = C_GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tim_d = tim_q - 1'b1;
            end
         end

         ST_GAP: begin
            if (tim_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               tim_d = tim_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      s_d    = (state_d == ST_PULSE_S);
      r_d    = (state_d == ST_PULSE_R);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tim_q      <= '0;
         set_req_q  <= 1'b0;
         rst_req_q  <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tim_q      <= tim_d;
         set_req_q  <= set_req_d;
         rst_req_q  <= rst_req_d;
         s_q        <= s_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_drive_ctrl
// Purpose  : Directed self-checking bench for sr_drive_ctrl. One instance uses
//            the default timing; a second uses PULSE_CYCLES=3, GAP_CYCLES=0.
//            Edge k below is the k-th rising edge after the stimulus starts;
//            inputs set before edge k are sampled at edge k, outputs are
//            observed 1 time unit after edge k.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_drive_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic btn_set, btn_rst;
   logic s, r, busy, conflict;
   logic btn_set6, btn_rst6;
   logic s6, r6, busy6, conflict6;

   int total = 0;
   int bad   = 0;
   int busy_cnt;

   always #5 clk = ~clk;

   sr_drive_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .btn_set  (btn_set),
      .btn_rst  (btn_rst),
      .s        (s),
      .r        (r),
      .busy     (busy),
      .conflict (conflict)
   );

   sr_drive_ctrl #(
      .DEB_CYCLES   (4),
      .PULSE_CYCLES (3),
      .GAP_CYCLES   (0)
   ) dut6 (
      .clk      (clk),
      .rst      (rst),
      .btn_set  (btn_set6),
      .btn_rst  (btn_rst6),
      .s        (s6),
      .r        (r6),
      .busy     (busy6),
      .conflict (conflict6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int k, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; btn_set = 1'b0; btn_rst = 1'b0; btn_set6 = 1'b0; btn_rst6 = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_s", 0, s, 1'b0);
      chk("rst_r", 0, r, 1'b0);
      chk("rst_busy", 0, busy, 1'b0);
      chk("rst_conflict", 0, conflict, 1'b0);
      chk("rst_s6", 0, s6, 1'b0);

      // T1: set held -> s at edges 8,9; gap at 10
      rst = 1'b0;
      btn_set = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         chk("t1_s", k, s, (k == 8 || k == 9));
         chk("t1_r", k, r, 1'b0);
         chk("t1_busy", k, busy, (k >= 8 && k <= 10));
      end
      // Release: falling debounced level must not pulse
      btn_set = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("t1_rel_s", k, s, 1'b0);
      end

      // T2: 3-cycle glitch then final rise first sampled at edge 5 -> s at 12,13
      for (int k = 1; k <= 18; k++) begin
         btn_set = (k <= 3 || k >= 5);
         tick();
         chk("t2_s", k, s, (k == 12 || k == 13));
         chk("t2_r", k, r, 1'b0);
      end
      btn_set = 1'b0;
      for (int k = 1; k <= 12; k++) tick();

      // T3: simultaneous rise -> both requests pending together -> conflict at edge 8
      btn_set = 1'b1;
      btn_rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("t3_conflict", k, conflict, (k == 8));
         chk("t3_s", k, s, 1'b0);
         chk("t3_r", k, r, 1'b0);
         chk("t3_busy", k, busy, 1'b0);
      end
      btn_set = 1'b0;
      btn_rst = 1'b0;
      for (int k = 1; k <= 12; k++) tick();

      // T4: set from edge 1, reset from edge 3 -> s 8,9; gap 10; r 12,13; gap 14
      busy_cnt = 0;
      for (int k = 1; k <= 18; k++) begin
         btn_set = 1'b1;
         btn_rst = (k >= 3);
         tick();
         if (busy === 1'b1) busy_cnt++;
         chk("t4_s", k, s, (k == 8 || k == 9));
         chk("t4_r", k, r, (k == 12 || k == 13));
         chk("t4_s_and_r", k, s & r, 1'b0);
         chk("t4_busy", k, busy, ((k >= 8 && k <= 10) || (k >= 12 && k <= 14)));
      end
      total++;
      assert (busy_cnt == 6)
      else begin
         bad++;
         $error("FAIL t4_busy_cycles observed=%0d expected=6", busy_cnt);
      end
      btn_set = 1'b0;
      btn_rst = 1'b0;
      for (int k = 1; k <= 12; k++) tick();

      // T5: reset applied at edge 9 (second s cycle), button held -> new s at 17,18
      for (int k = 1; k <= 21; k++) begin
         btn_set = 1'b1;
         rst = (k == 9);
         tick();
         chk("t5_s", k, s, (k == 8 || k == 17 || k == 18));
         chk("t5_busy", k, busy, (k == 8 || (k >= 17 && k <= 19)));
      end
      rst = 1'b0;
      btn_set = 1'b0;
      for (int k = 1; k <= 12; k++) tick();

      // T6: PULSE=3, GAP=0 instance; two presses 20 cycles apart -> s 8..10 and 28..30
      for (int k = 1; k <= 34; k++) begin
         btn_set6 = (k <= 8) || (k >= 21 && k <= 28);
         tick();
         chk("t6_s", k, s6, ((k >= 8 && k <= 10) || (k >= 28 && k <= 30)));
         chk("t6_busy", k, busy6, ((k >= 8 && k <= 10) || (k >= 28 && k <= 30)));
         chk("t6_r", k, r6, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
